// File: rtl/posit_normalize_product_es3_pkg.sv
// Shared definitions for the es=3 raw-product encoder: widths, raw-value layout
// and the per-stage pipeline records.
package posit_defines_es3;
  localparam int NBITS   = 32;
  localparam int ES      = 3;
  localparam int MBITS   = 54;
  localparam int SCALE_W = 10;
  localparam int POSIT_SERIALIZED_WIDTH_PRODUCT_ES3 = 1 + SCALE_W + MBITS + 2;
  localparam int SHIFT_W = 2*NBITS + MBITS;
  localparam int SHIFT_S = 7;

  localparam logic [NBITS-1:0] MAXPOS_ES3 = 32'h7FFF_FFFF;
  localparam logic [NBITS-1:0] MINPOS_ES3 = 32'h0000_0001;
  localparam logic [NBITS-1:0] NAR_ES3    = 32'h8000_0000;
  localparam logic signed [SCALE_W-1:0] MAX_SCALE_ES3 = 10'sd240;

  typedef struct packed {
    logic                      sgn;
    logic signed [SCALE_W-1:0] scale;
    logic [MBITS-1:0]          fraction;
    logic                      inf;
    logic                      zero;
  } value_product;

  // Decoded operand after S1
  typedef struct packed {
    logic               sgn;
    logic               inf;
    logic               zero;
    logic               sat_hi;
    logic               sat_lo;
    logic               kneg;
    logic [SHIFT_S-1:0] shamt;
    logic [ES-1:0]      e;
    logic [MBITS-1:0]   fraction;
  } s1_t;

  // Truncated magnitude plus rounding bits after S2
  typedef struct packed {
    logic             sgn;
    logic             inf;
    logic             zero;
    logic             sat_hi;
    logic             sat_lo;
    logic [NBITS-2:0] mag;
    logic             g;
    logic             s;
  } s2_t;

  function automatic value_product deserialize_prod(
    input logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] v);
    value_product p;
    p.sgn      = v[66];
    p.scale    = v[65:56];
    p.fraction = v[55:2];
    p.inf      = v[1];
    p.zero     = v[0];
    return p;
  endfunction
endpackage

// File: rtl/posit_normalize_product_es3_shift_right.sv
// Parameterised right shifter; arith=1 replicates the input MSB into vacated bits.
module shift_right #(
  parameter int N = 118,
  parameter int S = 7
) (
  input  logic [N-1:0] din,
  input  logic [S-1:0] shamt,
  input  logic         arith,
  output logic [N-1:0] dout
);
  logic         fill;
  logic [2*N-1:0] ext, ext_sh;

  assign fill   = arith & din[N-1];
  assign ext    = {{N{fill}}, din};
  assign ext_sh = ext >> shamt;
  assign dout   = ext_sh[N-1:0];
endmodule

// File: rtl/posit_normalize_product_es3.sv
// Three-stage encoder: raw posit product (sign/scale/fraction/flags) to a 32-bit
// es=3 posit with round-to-nearest-even and saturation to maxpos/minpos.
module posit_normalize_product_es3
  import posit_defines_es3::*;
(
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] in_product,
  output logic [NBITS-1:0]                              result,
  output logic                                          done
);
  localparam int STAGES = 3;
  localparam int PAD_W  = SHIFT_W - 2 - ES - MBITS;

  logic [STAGES:1] vld_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], 1'b0};
      if (start) vld_pipe[1] <= 1'b1;
    end
  end

  // ---------------- S1: decode ----------------
  value_product in_v;
  s1_t          s1_d, s1_q;
  logic [SHIFT_S-1:0] regime_k;

  assign in_v     = deserialize_prod(in_product);
  assign regime_k = in_v.scale[SCALE_W-1:ES];

  always_comb begin
    s1_d          = '0;
    s1_d.sgn      = in_v.sgn;
    s1_d.inf      = in_v.inf;
    s1_d.zero     = in_v.zero;
    s1_d.sat_hi   = $signed(in_v.scale) > MAX_SCALE_ES3;
    s1_d.sat_lo   = $signed(in_v.scale) < -MAX_SCALE_ES3;
    s1_d.kneg     = in_v.scale[SCALE_W-1];
    // k>=0 shifts "10.." right by k; k<0 shifts "01.." right by -k-1 (= ~k)
    s1_d.shamt    = s1_d.kneg ? ~regime_k : regime_k;
    s1_d.e        = in_v.scale[ES-1:0];
    s1_d.fraction = in_v.fraction;
  end

  always_ff @(posedge clk) s1_q <= s1_d;

  // ---------------- S2: build regime string ----------------
  logic [SHIFT_W-1:0] shift_din, shift_dout;
  s2_t                s2_d, s2_q;

  assign shift_din = {~s1_q.kneg, s1_q.kneg, s1_q.e, s1_q.fraction, {PAD_W{1'b0}}};

  shift_right #(.N(SHIFT_W), .S(SHIFT_S)) u_shift (
    .din   (shift_din),
    .shamt (s1_q.shamt),
    .arith (1'b1),
    .dout  (shift_dout)
  );

  always_comb begin
    s2_d        = '0;
    s2_d.sgn    = s1_q.sgn;
    s2_d.inf    = s1_q.inf;
    s2_d.zero   = s1_q.zero;
    s2_d.sat_hi = s1_q.sat_hi;
    s2_d.sat_lo = s1_q.sat_lo;
    s2_d.mag    = shift_dout[SHIFT_W-1 -: NBITS-1];
    s2_d.g      = shift_dout[SHIFT_W-NBITS];
    s2_d.s      = |shift_dout[SHIFT_W-NBITS-1:0];
  end

  always_ff @(posedge clk) s2_q <= s2_d;

  // ---------------- S3: round, saturate, sign, specials ----------------
  logic             rnd;
  logic [NBITS-1:0] sum, res_d;
  logic [NBITS-2:0] mag_f;

  always_comb begin
    rnd   = s2_q.g & (s2_q.mag[0] | s2_q.s);
    sum   = {1'b0, s2_q.mag} + {{(NBITS-1){1'b0}}, rnd};
    mag_f = sum[NBITS-2:0];
    if (s2_q.sat_hi || sum[NBITS-1])
      mag_f = MAXPOS_ES3[NBITS-2:0];
    else if (s2_q.sat_lo || (sum == '0))
      mag_f = MINPOS_ES3[NBITS-2:0];
    res_d = s2_q.sgn ? -{1'b0, mag_f} : {1'b0, mag_f};
    if (s2_q.inf)       res_d = NAR_ES3;
    else if (s2_q.zero) res_d = '0;
  end

  // result holds through bubbles
  always_ff @(posedge clk) begin
    if (reset)                 result <= '0;
    else if (vld_pipe[STAGES-1]) result <= res_d;
  end

  assign done = vld_pipe[STAGES];
endmodule

// File: tb/tb_posit_normalize_product_es3.sv
// Bench for posit_normalize_product_es3: directed vector table, random stream
// against a bit-string reference model, and a mid-flight reset sequence.
module tb_posit_normalize_product_es3;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [66:0] in_product;
  logic [31:0] result;
  logic        done;

  int total = 0;
  int bad   = 0;

  posit_normalize_product_es3 dut (
    .clk(clk), .reset(reset), .start(start), .in_product(in_product),
    .result(result), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    int          scale;
    logic [53:0] frac;
    logic        inf;
    logic        zero;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  typedef struct {
    logic        v;
    logic        z;
    logic [31:0] r;
    string       nm;
  } exp_t;

  exp_t q[$];

  function automatic logic [66:0] pack(input logic sgn, input int scale,
                                       input logic [53:0] frac, input logic inf, input logic zero);
    logic [9:0] sc;
    sc = scale[9:0];
    return {sgn, sc, frac, inf, zero};
  endfunction

  // Reference: spell out the posit bit string, then round on it.
  function automatic logic [31:0] ref_model(input logic sgn, input int scale,
                                            input logic [53:0] frac, input logic inf, input logic zero);
    bit     bits[$];
    int     k, e;
    longint mag, rounded;
    bit     g, s;
    logic [31:0] m32;
    if (inf)  return 32'h8000_0000;
    if (zero) return 32'h0000_0000;
    if (scale > 240) mag = 64'h7FFF_FFFF;
    else if (scale < -240) mag = 1;
    else begin
      k = (scale >= 0) ? scale / 8 : -((7 - scale) / 8);
      e = scale - 8 * k;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) bits.push_back(e[i]);
      for (int i = 53; i >= 0; i--) bits.push_back(frac[i]);
      mag = 0;
      for (int i = 0; i < 31; i++) mag = mag * 2 + longint'(bits[i]);
      g = bits[31];
      s = 1'b0;
      for (int i = 32; i < bits.size(); i++) s = s | bits[i];
      rounded = mag + longint'(g & ((mag % 2 == 1) | s));
      if (rounded > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
      else if (rounded == 0) mag = 1;
      else mag = rounded;
    end
    m32 = mag[31:0];
    return sgn ? (~m32 + 32'd1) : m32;
  endfunction

  task automatic step(input logic rst, input logic st, input logic [66:0] p,
                      input logic [31:0] r, input string nm);
    exp_t e;
    reset      = rst;
    start      = st;
    in_product = p;
    if (rst) begin
      foreach (q[i]) begin q[i].v = 1'b0; q[i].z = 1'b1; end
    end
    q.push_back('{st & ~rst, rst, r, nm});
    @(posedge clk);
    #1;
    e = q.pop_front();
    total++;
    if (done !== e.v) begin
      bad++;
      $display("FAIL %s done: got %0b want %0b", e.nm, done, e.v);
    end
    if (e.v) begin
      total++;
      if (result !== e.r) begin
        bad++;
        $display("FAIL %s result: got %08h want %08h", e.nm, result, e.r);
      end
    end
    if (e.z) begin
      total++;
      if (result !== 32'h0) begin
        bad++;
        $display("FAIL %s reset result: got %08h want 00000000", e.nm, result);
      end
    end
  endtask

  task automatic bubble(input string nm);
    step(1'b0, 1'b0, 67'h0, 32'h0, nm);
  endtask

  vec_t tv[$];

  initial begin
    logic        sgn, inf, zero;
    int          sc;
    logic [63:0] r64;
    logic [53:0] fr;

    tv.push_back('{1'b0,    0, 54'h0,        1'b0, 1'b0, 32'h4000_0000, "one"});
    tv.push_back('{1'b0,    1, 54'h0,        1'b0, 1'b0, 32'h4400_0000, "scale1"});
    tv.push_back('{1'b0,    8, 54'h0,        1'b0, 1'b0, 32'h6000_0000, "scale8"});
    tv.push_back('{1'b0,   -1, 54'h0,        1'b0, 1'b0, 32'h3C00_0000, "scale-1"});
    tv.push_back('{1'b1,    0, 54'h0,        1'b0, 1'b0, 32'hC000_0000, "neg_one"});
    tv.push_back('{1'b0,    0, 54'h8000000,  1'b0, 1'b0, 32'h4000_0000, "tie_even"});
    tv.push_back('{1'b0,    0, 54'h18000000, 1'b0, 1'b0, 32'h4000_0002, "tie_odd"});
    tv.push_back('{1'b0,    0, 54'h8000001,  1'b0, 1'b0, 32'h4000_0001, "sticky"});
    tv.push_back('{1'b0,  300, 54'h0,        1'b0, 1'b0, 32'h7FFF_FFFF, "sat_hi"});
    tv.push_back('{1'b0, -300, 54'h0,        1'b0, 1'b0, 32'h0000_0001, "sat_lo"});
    tv.push_back('{1'b1, -300, 54'h0,        1'b0, 1'b0, 32'hFFFF_FFFF, "sat_lo_neg"});
    tv.push_back('{1'b0,  240, {54{1'b1}},   1'b0, 1'b0, 32'h7FFF_FFFF, "scale240"});
    tv.push_back('{1'b1,  240, 54'h0,        1'b0, 1'b0, 32'h8000_0001, "scale240_neg"});
    tv.push_back('{1'b0, -240, 54'h0,        1'b0, 1'b0, 32'h0000_0001, "scale-240"});
    tv.push_back('{1'b0,    5, 54'h0,        1'b0, 1'b1, 32'h0000_0000, "zero"});
    tv.push_back('{1'b1,    5, 54'h0,        1'b1, 1'b0, 32'h8000_0000, "inf"});
    tv.push_back('{1'b0,    0, 54'h0,        1'b1, 1'b1, 32'h8000_0000, "inf_zero"});

    q.push_back('{1'b0, 1'b1, 32'h0, "init"});
    q.push_back('{1'b0, 1'b1, 32'h0, "init"});
    reset = 1'b1; start = 1'b0; in_product = '0;
    step(1'b1, 1'b0, 67'h0, 32'h0, "reset");
    step(1'b1, 1'b0, 67'h0, 32'h0, "reset");

    // Back-to-back directed vectors with one bubble
    for (int i = 0; i < tv.size(); i++) begin
      if (i == 6) bubble("bubble");
      step(1'b0, 1'b1, pack(tv[i].sgn, tv[i].scale, tv[i].frac, tv[i].inf, tv[i].zero),
           tv[i].exp, tv[i].nm);
    end
    bubble("drain"); bubble("drain");

    // Random stream with random bubbles
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        bubble("rand_bubble");
      end else begin
        sgn  = 1'($urandom_range(0, 1));
        inf  = ($urandom_range(0, 19) == 0);
        zero = ($urandom_range(0, 19) == 0);
        sc   = int'($urandom_range(0, 520)) - 260;
        r64  = {$urandom, $urandom};
        fr   = r64[53:0];
        if ($urandom_range(0, 3) == 0) fr[29:0] = '0;
        if ($urandom_range(0, 7) == 0) fr = 54'h0;
        step(1'b0, 1'b1, pack(sgn, sc, fr, inf, zero),
             ref_model(sgn, sc, fr, inf, zero), "random");
      end
    end
    bubble("drain"); bubble("drain");

    // Reset with two operands in flight, then a fresh operand
    step(1'b0, 1'b1, pack(1'b0, 8, 54'h0, 1'b0, 1'b0), 32'h6000_0000, "inflight_a");
    step(1'b0, 1'b1, pack(1'b0, 1, 54'h0, 1'b0, 1'b0), 32'h4400_0000, "inflight_b");
    step(1'b1, 1'b1, pack(1'b0, 0, 54'h0, 1'b0, 1'b0), 32'h4000_0000, "during_rst");
    step(1'b0, 1'b1, pack(1'b1, -1, 54'h0, 1'b0, 1'b0), 32'hC400_0000, "after_rst");
    bubble("drain"); bubble("drain"); bubble("drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
